// File: rtl/halo_drain_seq.sv
// Halo-exchange handshake and accumulator-bank drain sequencer for one tile.
// Optional watchdog on the CTS/EXCH waits is compiled in with `define HALO_TIMEOUT_EN.
module halo_drain_seq #(
    parameter int unsigned BANK_COUNT     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned BankW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             channel_group_done,
    input  logic [7:0]       neighbor_cts,
    input  logic [7:0]       neighbor_exchange_done,
    input  logic             local_send_done,
    input  logic             bank_drained,
    output logic             clear_to_send,
    output logic             exchange_done,
    output logic [BankW-1:0] buffer_bank_read,
    output logic             drain_start,
    output logic             cycle_done,
    output logic             busy,
    output logic             timeout_err
);

    if (BANK_COUNT < 2) begin : g_bad_banks
        $error("BANK_COUNT must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StCts,
        StExch,
        StDrain,
        StDone
    } state_e;

    localparam logic [BankW-1:0] LastBank = BankW'(BANK_COUNT - 1);

    state_e           state_q, state_d;
    logic [BankW-1:0] bank_q, bank_d;
    logic [7:0]       done_seen_q, done_seen_d;
    logic             local_seen_q, local_seen_d;
    logic             drain_start_q, drain_start_d;

`ifdef HALO_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

    logic [TimeoutW-1:0] wd_cnt_q, wd_cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic                waiting;
`endif

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        done_seen_d   = done_seen_q;
        local_seen_d  = local_seen_q;
        drain_start_d = 1'b0;
`ifdef HALO_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            StIdle: begin
                if (channel_group_done) begin
                    state_d = StCts;
`ifdef HALO_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            StCts: begin
                if (neighbor_cts == 8'hFF) begin
                    state_d = StExch;
                end
            end
            StExch: begin
                // Same-cycle arrivals count toward the exit condition.
                done_seen_d  = done_seen_q | neighbor_exchange_done;
                local_seen_d = local_seen_q | local_send_done;
                if (done_seen_d == 8'hFF && local_seen_d) begin
                    state_d       = StDrain;
                    bank_d        = '0;
                    drain_start_d = 1'b1;
                end
            end
            StDrain: begin
                // bank_drained is not trusted in the cycle the drain is launched.
                if (!drain_start_q && bank_drained) begin
                    if (bank_q == LastBank) begin
                        state_d = StDone;
                    end else begin
                        bank_d        = bank_q + BankW'(1);
                        drain_start_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d      = StIdle;
                bank_d       = '0;
                done_seen_d  = '0;
                local_seen_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef HALO_TIMEOUT_EN
        waiting = (state_q == StCts) || (state_q == StExch);
        if (waiting && wd_cnt_q == TimeoutLast) begin
            state_d       = StDone;
            bank_d        = bank_q;
            drain_start_d = 1'b0;
            timeout_err_d = 1'b1;
        end
        if (state_d != state_q || !waiting) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + TimeoutW'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            bank_q        <= '0;
            done_seen_q   <= '0;
            local_seen_q  <= 1'b0;
            drain_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            done_seen_q   <= done_seen_d;
            local_seen_q  <= local_seen_d;
            drain_start_q <= drain_start_d;
        end
    end

`ifdef HALO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy             = (state_q != StIdle);
    assign clear_to_send    = (state_q == StCts) || (state_q == StExch);
    assign exchange_done    = local_seen_q;
    assign buffer_bank_read = bank_q;
    assign drain_start      = drain_start_q;
    assign cycle_done       = (state_q == StDone);

endmodule

// File: tb/tb_halo_drain_seq.sv
// Randomized bench for halo_drain_seq: each sequence is planned as event times and the
// expected output timeline is derived from that plan with plain arithmetic.
module tb_halo_drain_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned BW = $clog2(NB);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cgd;
    logic [7:0]    nbr_cts;
    logic [7:0]    nbr_done;
    logic          loc_done;
    logic          bank_drained;
    logic          clear_to_send;
    logic          exchange_done;
    logic [BW-1:0] buffer_bank_read;
    logic          drain_start;
    logic          cycle_done;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    halo_drain_seq #(
        .BANK_COUNT    (NB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .channel_group_done    (cgd),
        .neighbor_cts          (nbr_cts),
        .neighbor_exchange_done(nbr_done),
        .local_send_done       (loc_done),
        .bank_drained          (bank_drained),
        .clear_to_send         (clear_to_send),
        .exchange_done         (exchange_done),
        .buffer_bank_read      (buffer_bank_read),
        .drain_start           (drain_start),
        .cycle_done            (cycle_done),
        .busy                  (busy),
        .timeout_err           (timeout_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Sequence plan: CTS stall length, per-source EXCH arrival offsets, per-bank drain time.
    int c_len;
    int t_nb[8];
    bit lvl_nb[8];
    int t_loc;
    bit lvl_loc;
    int w[NB];
    int abort_k;
    bit garbage;

    task automatic zero_inputs();
        cgd = 1'b0; nbr_cts = '0; nbr_done = '0; loc_done = 1'b0; bank_drained = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_cts"}, clear_to_send, 0);
        check_eq({tag, "_xdone"}, exchange_done, 0);
        check_eq({tag, "_bank"}, buffer_bank_read, 0);
        check_eq({tag, "_dstart"}, drain_start, 0);
        check_eq({tag, "_cdone"}, cycle_done, 0);
        check_eq({tag, "_terr"}, timeout_err, 0);
    endtask

    task automatic min_plan();
        c_len = 0; t_loc = 1; lvl_loc = 1'b1; abort_k = -1; garbage = 1'b1;
        for (int b = 0; b < 8; b++) begin t_nb[b] = 1; lvl_nb[b] = 1'b1; end
        for (int i = 0; i < NB; i++) w[i] = 2;
    endtask

    task automatic run_seq();
        int x, s0, e_done, m, j;
        int s[NB];
        int exp_bank;
        bit exp_ds, bd;
        logic [7:0] r;
        x = t_loc;
        for (int b = 0; b < 8; b++) if (t_nb[b] > x) x = t_nb[b];
        s0 = c_len + 1 + x;
        s[0] = s0;
        for (int i = 1; i < NB; i++) s[i] = s[i-1] + w[i-1];
        e_done = s[NB-1] + w[NB-1];

        zero_inputs();
        cgd = 1'b1;
        for (int k = 0; k <= e_done + 1; k++) begin
            @(posedge clk); #1;
            exp_ds = 1'b0; exp_bank = 0;
            for (int i = 0; i < NB; i++) begin
                if (k == s[i]) exp_ds = 1'b1;
                if (k >= s[i]) exp_bank = i;
            end
            check_eq("busy", busy, k <= e_done);
            check_eq("clear_to_send", clear_to_send, k < s0);
            check_eq("drain_start", drain_start, exp_ds);
            if (k >= s0 && k < e_done) check_eq("bank", buffer_bank_read, exp_bank);
            check_eq("cycle_done", cycle_done, k == e_done);
            check_eq("exchange_done", exchange_done, (k >= c_len + 1 + t_loc) && (k <= e_done));
            check_eq("timeout_err", timeout_err, 0);

            if (k == abort_k) begin
                zero_inputs();
                reset_n = 1'b0;
                @(posedge clk); #1;
                check_all_zero("abort");
                reset_n = 1'b1;
                for (int q = 0; q < 12; q++) begin
                    @(posedge clk); #1;
                    check_eq("abort_no_cdone", cycle_done, 0);
                    check_eq("abort_idle", busy, 0);
                end
                return;
            end

            // Inputs sampled at edge k+1.
            j = k + 1;
            m = j - (c_len + 1);
            if (j > e_done + 1) begin
                zero_inputs();
            end else begin
                cgd = garbage ? 1'($urandom) : 1'b0;
                if (j <= c_len) begin
                    r = 8'($urandom);
                    nbr_cts = (r == 8'hFF) ? 8'h7F : r;
                end else if (j == c_len + 1) begin
                    nbr_cts = 8'hFF;
                end else begin
                    nbr_cts = 8'($urandom);
                end
                if (m >= 1 && m <= x) begin
                    for (int b = 0; b < 8; b++)
                        nbr_done[b] = (m == t_nb[b]) || (lvl_nb[b] && m > t_nb[b]);
                    loc_done = (m == t_loc) || (lvl_loc && m > t_loc);
                end else begin
                    nbr_done = garbage ? 8'($urandom) : 8'h00;
                    loc_done = garbage ? 1'($urandom) : 1'b0;
                end
                bd = 1'b0;
                for (int i = 0; i < NB; i++) begin
                    if (j == s[i] + w[i]) bd = 1'b1;
                    else if (j == s[i] + 1 && garbage) bd = 1'($urandom);
                end
                bank_drained = bd;
            end
        end
        zero_inputs();
    endtask

    initial begin
        int n_cd, n_ds, done_k;
        reset_n = 1'b0;
        zero_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // All handshakes ready: latency and bank order.
        min_plan();
        run_seq();

`ifndef HALO_TIMEOUT_EN
        // CTS stalled on 8'h7F-like patterns for 20 cycles.
        min_plan();
        c_len = 20;
        run_seq();
`endif

        // Neighbor dones one per cycle 0..7, local send done last.
        min_plan();
        for (int b = 0; b < 8; b++) begin t_nb[b] = b + 1; lvl_nb[b] = 1'b0; end
        t_loc = 9; lvl_loc = 1'b0;
        run_seq();

        // Reset while bank 2 is being drained.
        min_plan();
        abort_k = 6;
        run_seq();

        for (int n = 0; n < 40; n++) begin
            min_plan();
`ifdef HALO_TIMEOUT_EN
            c_len = $urandom_range(0, 10);
`else
            c_len = $urandom_range(0, 25);
`endif
            for (int b = 0; b < 8; b++) begin
                t_nb[b] = $urandom_range(1, 6);
                lvl_nb[b] = 1'($urandom);
            end
            t_loc = $urandom_range(1, 6);
            lvl_loc = 1'($urandom);
            for (int i = 0; i < NB; i++) w[i] = $urandom_range(2, 5);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_seq();
        end

`ifdef HALO_TIMEOUT_EN
        // Neighbors never clear to send: watchdog ends the sequence without draining.
        zero_inputs();
        cgd = 1'b1;
        n_cd = 0; n_ds = 0; done_k = -1;
        for (int k = 0; k <= TO + 4; k++) begin
            @(posedge clk); #1;
            cgd = 1'b0;
            if (drain_start) n_ds++;
            if (cycle_done) begin
                n_cd++;
                if (done_k < 0) done_k = k;
            end
            if (k < TO) check_eq("to_err_early", timeout_err, 0);
        end
        check_eq("to_done_at", done_k, TO);
        check_eq("to_cdone_count", n_cd, 1);
        check_eq("to_no_drain", n_ds, 0);
        check_eq("to_err_sticky", timeout_err, 1);
        check_eq("to_idle", busy, 0);

        // Next accepted channel_group_done clears the error.
        min_plan();
        run_seq();
`else
        n_cd = 0; n_ds = 0; done_k = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
